rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
Write-back scheduler and scoreboard for the register file. Shares its single synchronous write port between the ALU write-back and the load-unit write-back using load-priority arbitration with an anti-starvation guard. Keeps a busy bit per register so decode can stall on RAW hazards and refuse WAW issues. Sits between the execute/memory stages and the register file write port.

Parameters:
DATA_W, 16, write data width
RF_ADDR_W, 4, register address width (2**RF_ADDR_W registers tracked)
STARVE_MAX, 3, consecutive denied ALU cycles before the ALU gets priority

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
iss_valid  in  1  decode issues an instruction that writes iss_addr
iss_addr  in  RF_ADDR_W  destination register of the issuing instruction
iss_ready  out  1  issue accepted this cycle (combinational)
chk1_en  in  1  source operand 1 is used
chk1_addr  in  RF_ADDR_W  source register 1
chk2_en  in  1  source operand 2 is used
chk2_addr  in  RF_ADDR_W  source register 2
chk_stall  out  1  an enabled source is busy (combinational)
a_valid  in  1  ALU write-back request
a_addr  in  RF_ADDR_W  ALU destination
a_data  in  DATA_W  ALU result
a_ready  out  1  ALU request granted this cycle (combinational)
m_valid  in  1  load write-back request
m_addr  in  RF_ADDR_W  load destination
m_data  in  DATA_W  load data
m_ready  out  1  load request granted this cycle (combinational)
rf_we  out  1  register file write enable (registered)
rf_w_addr  out  RF_ADDR_W  register file write address (registered)
rf_w_data  out  DATA_W  register file write data (registered)
wb_orphan  out  1  one-cycle pulse: a write-back landed on a non-busy register (registered)

Behaviour:
- Reset: while rst=1, all busy bits are 0, rf_we=0, rf_w_addr=0, rf_w_data=0, wb_orphan=0, state=PRI_M, starve counter=0. Asserting rst mid-operation drops any registered write; it is never written.
- Arbiter FSM, two states:
  - PRI_M: grant m if m_valid, otherwise grant a if a_valid.
  - PRI_A: grant a if a_valid, otherwise grant m if m_valid.
- Starve counter:
  - Increments on each edge where a_valid=1 and a is not granted; saturates at STARVE_MAX.
  - Clears to 0 on any a grant.
  - On the edge where it reaches STARVE_MAX, the state moves to PRI_A.
  - After an a grant, the state returns to PRI_M.
- At most one grant per cycle. The write port never back-pressures, so ready equals grant.
- The requester holds valid, addr and data until ready is sampled high.
- Latency: a grant at edge N sets rf_we/rf_w_addr/rf_w_data at edge N; the register file stores the data at edge N+1. If there is no grant at edge N, rf_we=0 after edge N.
- Scoreboard:
  - iss_ready = ~busy[iss_addr]. This includes the cycle in which that register is being cleared; the issue is simply retried next cycle.
  - iss_valid & iss_ready at an edge sets busy[iss_addr].
  - rf_we=1 at an edge clears busy[rf_w_addr] at that same edge. The data is therefore in the register file when chk_stall drops.
  - Set and clear on different addresses at the same edge both take effect.
- chk_stall = (chk1_en & busy[chk1_addr]) | (chk2_en & busy[chk2_addr]). Disabled sources never stall.
- Orphan write-back: if rf_we=1 and busy[rf_w_addr]=0 at an edge, the write still happens and wb_orphan=1 for the following cycle. Busy bits are unchanged.
- Same-address requests from a and m in one cycle: only the granted one is written that cycle; the other stays pending.

Test Plan:
- Reset, then check with no requests: rf_we=0, iss_ready=1 for all 16 addresses, chk_stall=0; raise rst mid-write -> rf_we=0 immediately, busy all 0.
- Issue r8 at edge 1; chk1_addr=8, chk1_en=1 -> chk_stall=1. At cycle 3, m_valid with addr 8, data 0x8000 -> m_ready=1; next cycle rf_we=1, rf_w_addr=8, rf_w_data=0x8000. chk_stall stays 1 until that write edge, then 0.
- Issue r3 while r3 is busy -> iss_ready=0; busy unchanged. Re-issue after the r3 write-back edge -> iss_ready=1.
- a_valid and m_valid held together continuously, r1 and r2 busy -> m granted 3 cycles, then a granted on the 4th, then m again. Total write order m,m,m,a,m…
- a_valid alone, writing 0xFFFF to non-busy r5 -> a_ready=1, register written, wb_orphan=1 for exactly one cycle.
- Disabled sources: chk1_en=0 with a busy chk1_addr -> chk_stall=0.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and register scoreboard: arbitrates the single register-file
// write port between ALU and load write-backs and tracks per-register busy bits.
module rf_wb_sched #(
  parameter int DATA_W     = 16,
  parameter int RF_ADDR_W  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [RF_ADDR_W-1:0] iss_addr,
  output logic                 iss_ready,
  input  logic                 chk1_en,
  input  logic [RF_ADDR_W-1:0] chk1_addr,
  input  logic                 chk2_en,
  input  logic [RF_ADDR_W-1:0] chk2_addr,
  output logic                 chk_stall,
  input  logic                 a_valid,
  input  logic [RF_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 m_valid,
  input  logic [RF_ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0]    m_data,
  output logic                 m_ready,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0]    rf_w_data,
  output logic                 wb_orphan
);

  localparam int NREG  = 1 << RF_ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {PRI_M, PRI_A} pri_t;

  pri_t                 r_state;
  pri_t                 w_state_nxt;
  logic [CNT_W-1:0]     r_starve;
  logic [CNT_W-1:0]     w_starve_nxt;
  logic [NREG-1:0]      r_busy;
  logic [NREG-1:0]      w_busy_nxt;
  logic                 w_gnt_a;
  logic                 w_gnt_m;

  assign a_ready   = w_gnt_a;
  assign m_ready   = w_gnt_m;
  assign iss_ready = ~r_busy[iss_addr];
  assign chk_stall = (chk1_en & r_busy[chk1_addr]) | (chk2_en & r_busy[chk2_addr]);

  // Arbitration and anti-starvation bookkeeping
  always_comb begin
    w_gnt_a      = 1'b0;
    w_gnt_m      = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    if (r_state == PRI_M) begin
      w_gnt_m = m_valid;
      w_gnt_a = a_valid & ~m_valid;
    end else begin
      w_gnt_a = a_valid;
      w_gnt_m = m_valid & ~a_valid;
    end
    if (w_gnt_a) begin
      w_starve_nxt = '0;
      w_state_nxt  = PRI_M;
    end else if (a_valid) begin
      if (r_starve != STARVE_LIM) w_starve_nxt = r_starve + 1'b1;
      if (w_starve_nxt == STARVE_LIM) w_state_nxt = PRI_A;
    end
  end

  // Clear before set so an issue onto a register hit by an orphan write still marks it busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_we) w_busy_nxt[rf_w_addr] = 1'b0;
    if (iss_valid & iss_ready) w_busy_nxt[iss_addr] = 1'b1;
  end

  // Registered write port, scoreboard and arbiter state
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= PRI_M;
      r_starve  <= '0;
      r_busy    <= '0;
      rf_we     <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      wb_orphan <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_starve  <= w_starve_nxt;
      r_busy    <= w_busy_nxt;
      rf_we     <= w_gnt_a | w_gnt_m;
      wb_orphan <= rf_we & ~r_busy[rf_w_addr];
      if (w_gnt_m) begin
        rf_w_addr <= m_addr;
        rf_w_data <= m_data;
      end else if (w_gnt_a) begin
        rf_w_addr <= a_addr;
        rf_w_data <= a_data;
      end
    end
  end

endmodule
